// File: rtl/event_sequencer.sv
// event_sequencer: drives the En/Slt pair of the dual event counter. After a Start it emits
// Count0 slot-0 pulses and then Count1*DIV slot-1 pulses, with optional idle gaps between
// pulses. Busy/Done handshaking is provided, along with Hold (freeze) and Abort (drop).
module event_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV   = 4,
    parameter int unsigned GAP   = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Count0,
    input  logic [WIDTH-1:0] Count1,
    input  logic             Hold,
    input  logic             Abort,
    output logic             EnOut,
    output logic             SltOut,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned LogDiv = $clog2(DIV);
    localparam int unsigned Rem1W  = WIDTH + LogDiv;
    localparam int unsigned GapW   = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [WIDTH-1:0] One0    = WIDTH'(1);
    localparam logic [Rem1W-1:0] One1    = Rem1W'(1);
    localparam logic [GapW-1:0]  GapLoad = GapW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StRun0,
        StRun1,
        StGapW,
        StFin
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem0_q, rem0_d;
    logic [Rem1W-1:0] rem1_q, rem1_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic             next_slot_q, next_slot_d;
    logic             en_q, en_d;
    logic             slt_q, slt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic in_seq;

    // Abort only acts on a running sequence, never in IDLE or FIN
    assign in_seq = (state_q == StRun0) || (state_q == StRun1) || (state_q == StGapW);

    // Next-state, remainder bookkeeping and next output values
    always_comb begin
        state_d     = state_q;
        rem0_d      = rem0_q;
        rem1_d      = rem1_q;
        gap_d       = gap_q;
        next_slot_d = next_slot_q;
        en_d        = 1'b0;
        slt_d       = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (Abort && in_seq) begin
            state_d     = StIdle;
            rem0_d      = '0;
            rem1_d      = '0;
            gap_d       = '0;
            next_slot_d = 1'b0;
            busy_d      = 1'b0;
        end else if (Hold) begin
            // everything frozen; Busy keeps its value, no pulse or Done
            busy_d = busy_q;
        end else begin
            unique case (state_q)
                StIdle: begin
                    busy_d = 1'b0;
                    if (Start) begin
                        rem0_d = Count0;
                        rem1_d = Rem1W'(Count1) << LogDiv;
                        if ((Count0 == '0) && (Count1 == '0)) begin
                            state_d = StFin;
                        end else if (Count0 != '0) begin
                            state_d = StRun0;
                        end else begin
                            state_d = StRun1;
                        end
                    end
                end
                StRun0: begin
                    en_d   = 1'b1;
                    busy_d = 1'b1;
                    rem0_d = rem0_q - One0;
                    if (GAP > 0) begin
                        gap_d       = GapLoad;
                        next_slot_d = (rem0_q == One0);
                        state_d     = StGapW;
                    end else if (rem0_q == One0) begin
                        state_d = (rem1_q != '0) ? StRun1 : StFin;
                    end
                end
                StRun1: begin
                    en_d   = 1'b1;
                    slt_d  = 1'b1;
                    busy_d = 1'b1;
                    rem1_d = rem1_q - One1;
                    if (GAP > 0) begin
                        gap_d       = GapLoad;
                        next_slot_d = 1'b1;
                        state_d     = StGapW;
                    end else if (rem1_q == One1) begin
                        state_d = StFin;
                    end
                end
                StGapW: begin
                    busy_d = 1'b1;
                    if (gap_q == '0) begin
                        if ((rem0_q == '0) && (rem1_q == '0)) begin
                            state_d = StFin;
                        end else begin
                            state_d = next_slot_q ? StRun1 : StRun0;
                        end
                    end else begin
                        gap_d = gap_q - GapW'(1);
                    end
                end
                StFin: begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, remainders and registered outputs with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            rem0_q      <= '0;
            rem1_q      <= '0;
            gap_q       <= '0;
            next_slot_q <= 1'b0;
            en_q        <= 1'b0;
            slt_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem0_q      <= rem0_d;
            rem1_q      <= rem1_d;
            gap_q       <= gap_d;
            next_slot_q <= next_slot_d;
            en_q        <= en_d;
            slt_q       <= slt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign EnOut  = en_q;
    assign SltOut = slt_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_event_sequencer.sv
// tb_event_sequencer: directed bench for event_sequencer. u_dut uses defaults (GAP=0),
// u_gap uses WIDTH=8, GAP=2 so the all-ones count case fits in a short run.
module tb_event_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, hold_a, abort_a;
    logic [15:0] c0_a, c1_a;
    logic        en_a, slt_a, busy_a, done_a;
    logic        start_b, hold_b, abort_b;
    logic [7:0]  c0_b, c1_b;
    logic        en_b, slt_b, busy_b, done_b;

    event_sequencer #(.WIDTH(16), .DIV(4), .GAP(0)) u_dut (
        .Clk(clk), .Reset(reset), .Start(start_a), .Count0(c0_a), .Count1(c1_a),
        .Hold(hold_a), .Abort(abort_a), .EnOut(en_a), .SltOut(slt_a), .Busy(busy_a),
        .Done(done_a)
    );

    event_sequencer #(.WIDTH(8), .DIV(4), .GAP(2)) u_gap (
        .Clk(clk), .Reset(reset), .Start(start_b), .Count0(c0_b), .Count1(c1_b),
        .Hold(hold_b), .Abort(abort_b), .EnOut(en_b), .SltOut(slt_b), .Busy(busy_b),
        .Done(done_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int n0, n1, first_at, second_at, last_at, done_at, done_cnt, busy_cnt;
        int busy_bad, order_bad, slt_bad, stray, min_space, timeout;
        int probe_en, probe_busy, probe_done, probe_slt;
    } res_t;

    typedef struct {
        int c0, c1, exp_n0, exp_n1, exp_done;
    } vec_t;

    // One sequence on DUT sel (0: u_dut, 1: u_gap); events are driven at negedge n
    // (edges after the Start-sampling edge) so they are sampled at edge n+1.
    task automatic run_seq(input int sel, input int c0, input int c1, input int expect_done,
                           input int limit, input int hold_from, input int hold_len,
                           input int abort_at, input int reset_at, input int inject_at,
                           input int probe_at, output res_t r);
        logic en, slt, busy, done;
        r = '{default: 0};
        r.first_at = -1; r.second_at = -1; r.last_at = -1; r.done_at = -1;
        r.min_space = 1000000;
        @(negedge clk);
        if (sel == 0) begin start_a = 1'b1; c0_a = c0[15:0]; c1_a = c1[15:0]; end
        else begin start_b = 1'b1; c0_b = c0[7:0]; c1_b = c1[7:0]; end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            en   = (sel != 0) ? en_b   : en_a;
            slt  = (sel != 0) ? slt_b  : slt_a;
            busy = (sel != 0) ? busy_b : busy_a;
            done = (sel != 0) ? done_b : done_a;
            if (n == probe_at) begin
                r.probe_en = int'(en); r.probe_busy = int'(busy);
                r.probe_done = int'(done); r.probe_slt = int'(slt);
            end
            if (en === 1'b1) begin
                if (r.done_at >= 0) r.stray++;
                else begin
                    if (slt === 1'b1) r.n1++;
                    else begin
                        r.n0++;
                        if (r.n1 > 0) r.order_bad++;
                    end
                    if (r.first_at < 0) r.first_at = n;
                    else if (r.second_at < 0) r.second_at = n;
                    if (r.last_at >= 0 && (n - r.last_at) < r.min_space)
                        r.min_space = n - r.last_at;
                    r.last_at = n;
                end
                if (busy !== 1'b1) r.busy_bad++;
            end else if (slt !== 1'b0) r.slt_bad++;
            if (busy === 1'b1) r.busy_cnt++;
            if (done === 1'b1) begin
                r.done_cnt++;
                if (r.done_at < 0) r.done_at = n;
                if (busy !== 1'b0 || en !== 1'b0) r.busy_bad++;
            end
            if (expect_done != 0 && r.done_at >= 0 && n >= r.done_at + 12) break;
            if (n == hold_from) begin hold_a = (sel == 0); hold_b = (sel != 0); end
            if (n == hold_from + hold_len) begin hold_a = 1'b0; hold_b = 1'b0; end
            abort_a = (n == abort_at) && (sel == 0);
            abort_b = (n == abort_at) && (sel != 0);
            reset   = (n == reset_at);
            if (n == inject_at) begin
                if (sel == 0) begin start_a = 1'b1; c0_a = 16'd9; c1_a = 16'd9; end
                else begin start_b = 1'b1; c0_b = 8'd9; c1_b = 8'd9; end
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
        end
        if (expect_done != 0 && r.done_at < 0) r.timeout = 1;
        start_a = 1'b0; start_b = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
        abort_a = 1'b0; abort_b = 1'b0; reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        res_t r;
        int   total;

        // c0, c1, slot-0 pulses, slot-1 pulses (c1*4), Done edge index (total+1)
        vecs[0] = '{3, 2, 3, 8, 12};
        vecs[1] = '{0, 0, 0, 0, 1};
        vecs[2] = '{5, 0, 5, 0, 6};
        vecs[3] = '{0, 3, 0, 12, 13};
        vecs[4] = '{1, 1, 1, 4, 6};
        vecs[5] = '{40, 10, 40, 40, 81};

        reset = 1'b1;
        start_a = 1'b0; hold_a = 1'b0; abort_a = 1'b0; c0_a = '0; c1_a = '0;
        start_b = 1'b0; hold_b = 1'b0; abort_b = 1'b0; c0_b = '0; c1_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_en", {31'd0, en_a}, 0);
        check("reset_slt", {31'd0, slt_a}, 0);
        check("reset_busy", {31'd0, busy_a}, 0);
        check("reset_done", {31'd0, done_a}, 0);
        check("reset_gap_outs", {28'd0, en_b, slt_b, busy_b, done_b}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_seq(0, vecs[i].c0, vecs[i].c1, 1, vecs[i].exp_done + 30, 0, 0, 0, 0, 0, 0, r);
            total = vecs[i].exp_n0 + vecs[i].exp_n1;
            check($sformatf("v%0d_timeout", i), r.timeout, 0);
            check($sformatf("v%0d_slot0", i), r.n0, vecs[i].exp_n0);
            check($sformatf("v%0d_slot1", i), r.n1, vecs[i].exp_n1);
            check($sformatf("v%0d_counter1", i), r.n1 / 4, vecs[i].c1);
            check($sformatf("v%0d_done_at", i), r.done_at, vecs[i].exp_done);
            check($sformatf("v%0d_done_cnt", i), r.done_cnt, 1);
            check($sformatf("v%0d_busy_cnt", i), r.busy_cnt, vecs[i].exp_done - 1);
            check($sformatf("v%0d_busy_bad", i), r.busy_bad, 0);
            check($sformatf("v%0d_order", i), r.order_bad, 0);
            check($sformatf("v%0d_slt_idle", i), r.slt_bad, 0);
            check($sformatf("v%0d_stray", i), r.stray, 0);
            if (total > 0) begin
                check($sformatf("v%0d_first_at", i), r.first_at, 1);
                check($sformatf("v%0d_contig", i), r.last_at - r.first_at + 1, total);
            end
        end

        // Hold on GAP=0: edges 3,4 held, pulses at 1,2,5..9, Done at 10
        run_seq(0, 3, 1, 1, 40, 2, 2, 0, 0, 0, 0, r);
        check("hold0_slot0", r.n0, 3);
        check("hold0_slot1", r.n1, 4);
        check("hold0_second", r.second_at, 2);
        check("hold0_last", r.last_at, 9);
        check("hold0_done_at", r.done_at, 10);
        check("hold0_busy_cnt", r.busy_cnt, 9);

        // Gap and hold: GAP=2, three held edges after the first pulse
        run_seq(1, 2, 0, 1, 40, 1, 3, 0, 0, 0, 0, r);
        check("gaphold_first", r.first_at, 1);
        check("gaphold_second", r.second_at, 7);
        check("gaphold_done_at", r.done_at, 10);
        check("gaphold_count", r.n0, 2);
        check("gaphold_busy_cnt", r.busy_cnt, 9);
        check("gaphold_done_cnt", r.done_cnt, 1);

        // Abort during the 4th pulse cycle
        run_seq(0, 10, 0, 0, 30, 0, 0, 4, 0, 0, 5, r);
        check("abort_pulses", r.n0 + r.n1, 4);
        check("abort_busy_next", r.probe_busy, 0);
        check("abort_en_next", r.probe_en, 0);
        check("abort_no_done", r.done_cnt, 0);
        run_seq(0, 2, 0, 1, 30, 0, 0, 0, 0, 0, 0, r);
        check("post_abort_pulses", r.n0, 2);
        check("post_abort_done_at", r.done_at, 3);

        // Reset in RUN1 (slot-1 pulses at edges 3..22)
        run_seq(0, 2, 5, 0, 40, 0, 0, 0, 6, 0, 7, r);
        check("rst_outs", {r.probe_en[7:0], r.probe_busy[7:0], r.probe_done[7:0],
                           r.probe_slt[7:0]}, 0);
        check("rst_slot0", r.n0, 2);
        check("rst_slot1", r.n1, 4);
        check("rst_no_done", r.done_cnt, 0);

        // Start while busy and in the FIN cycle is ignored
        run_seq(0, 3, 1, 1, 40, 0, 0, 0, 0, 3, 0, r);
        check("ign_busy_total", r.n0 + r.n1, 7);
        check("ign_busy_done_at", r.done_at, 8);
        check("ign_busy_stray", r.stray, 0);
        run_seq(0, 3, 1, 1, 40, 0, 0, 0, 0, 7, 0, r);
        check("ign_fin_total", r.n0 + r.n1, 7);
        check("ign_fin_done_cnt", r.done_cnt, 1);
        check("ign_fin_stray", r.stray, 0);

        // All-ones counts on the 8-bit GAP=2 instance: 255 + 1020 pulses, period 3
        run_seq(1, 255, 255, 1, 4000, 0, 0, 0, 0, 0, 0, r);
        check("wide_timeout", r.timeout, 0);
        check("wide_slot0", r.n0, 255);
        check("wide_slot1", r.n1, 1020);
        check("wide_min_space", r.min_space, 3);
        check("wide_last_at", r.last_at, 1 + 3 * 1274);
        check("wide_done_at", r.done_at, r.last_at + 3);
        check("wide_order", r.order_bad, 0);
        check("wide_busy_cnt", r.busy_cnt, 3825);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
